configs_loader: RTL and testbench
=================================

CONFIGS_LOADER -- requirements
Module: configs_loader

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- DATA_W, 32, configuration word width in bits.
- NUM_WORDS, 22, number of configuration words held.
- AUTO_COMMIT, 0, if 1, a completed load commits automatically.
- ADDR_W, clog2(NUM_WORDS), address/count width (derived; not overridden).

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_start  in  1  begin a burst load (sampled in IDLE only).
- io_start_addr  in  ADDR_W  first word index of the burst.
- io_start_count  in  ADDR_W+1  number of words in the burst.
- io_in_valid  in  1  io_d_in carries a word.
- io_in_ready  out  1  block accepts a word this cycle.
- io_d_in  in  DATA_W  configuration data word.
- io_commit  in  1  copy shadow bank to active bank.
- io_abort  in  1  terminate the burst in progress.
- io_rd_addr  in  ADDR_W  readback word index.
- io_rd_sel  in  1  readback source: 0 = active, 1 = shadow.
- io_rd_data  out  DATA_W  readback word, registered.
- io_busy  out  1  state is not IDLE.
- io_load_done  out  1  one-cycle pulse when a burst completes.
- io_commit_done  out  1  one-cycle pulse when a commit completes.
- io_err  out  1  one-cycle pulse on a rejected request.
- io_configs_out  out  NUM_WORDS*DATA_W  active bank; word i at bits [i*DATA_W +: DATA_W].

Function
REQ-003 The block SHALL hold two banks of NUM_WORDS x DATA_W flops: shadow (written by loads) and active (drives io_configs_out); io_configs_out SHALL change only on a commit or reset.
REQ-004 The FSM SHALL have three states: IDLE, LOAD and COMMIT.
REQ-005 In IDLE, io_start SHALL be accepted if count>=1 and start_addr+count<=NUM_WORDS; on acceptance the block loads addr=start_addr and remaining=count, then enters LOAD the next cycle.
REQ-006 In IDLE, a rejected io_start SHALL pulse io_err the next cycle and leave the state in IDLE.
REQ-007 io_in_ready SHALL be 1 exactly when the state is LOAD.
REQ-008 In LOAD, each cycle with io_in_valid & io_in_ready SHALL write shadow[addr]=io_d_in, increment addr and decrement remaining.
REQ-009 When the write makes remaining reach 0, the block SHALL pulse io_load_done the next cycle and go to COMMIT if AUTO_COMMIT=1, else to IDLE.
REQ-010 In IDLE, io_commit SHALL cause a transition to COMMIT; io_start asserted in the same cycle as io_commit SHALL have priority, and that io_commit is dropped.
REQ-011 In COMMIT (exactly one cycle), all active words SHALL take the shadow value at once; io_commit_done SHALL pulse the next cycle, and the state SHALL return to IDLE.
REQ-012 In LOAD, io_abort SHALL return the state to IDLE the next cycle with no write that cycle even if io_in_valid=1; no io_load_done is issued, already-written shadow words are retained, and active is unchanged.
REQ-013 io_start or io_commit outside IDLE SHALL be ignored, and io_err SHALL pulse.
REQ-014 io_rd_data SHALL present the selected bank word at io_rd_addr one cycle after the address is sampled; for io_rd_addr>=NUM_WORDS it SHALL present 0.
REQ-015 A readback of the shadow bank SHALL return the pre-write value when the same word is written in the same cycle.
REQ-016 io_busy SHALL be 1 in LOAD and COMMIT, and 0 in IDLE.

Reset
REQ-017 reset SHALL force state IDLE, both banks, addr, remaining and io_rd_data to 0, and all pulse outputs to 0, on the next rising edge, including mid-burst and mid-commit.
REQ-018 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-019 Shared package configs_pkg SHALL hold the state enum (IDLE/LOAD/COMMIT) and the clog2-based ADDR_W helper.
REQ-020 Shadow and active storage SHALL be one sub-module, configs_bank, instantiated once and providing: a single-word write port, a one-cycle bulk shadow-to-active copy, and two read ports.
REQ-021 The FSM, counters and handshake SHALL reside in configs_loader.

Verification
REQ-022 Reset with defaults, start addr=3 count=4, words 0xA0..0xA3 with valid gaps -> shadow[3..6]=A0..A3, io_load_done one pulse, io_configs_out all 0.
REQ-023 Follow with io_commit -> io_commit_done one cycle after COMMIT; word 5 of io_configs_out = 0xA2, other words 0.
REQ-024 start addr=20 count=3 -> io_err pulse, io_busy stays 0; start addr=21 count=1 -> accepted.
REQ-025 With AUTO_COMMIT=1, load count=2 at addr 0 (0x11, 0x22) -> io_load_done, then COMMIT, then io_commit_done; word0=0x11 and word1=0x22 active.
REQ-026 Abort after 2 of 5 words with io_in_valid=1 -> third word not written, active unchanged, IDLE next cycle; io_start during LOAD -> io_err pulse.
REQ-027 Assert reset mid-burst after 1 word -> all outputs 0 next cycle; readback io_rd_sel=1 addr=0 -> 0.

Source files
------------

// File: rtl/configs_pkg.sv
// Shared types and helpers for the configuration loader.
package configs_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StCommit = 2'd2
   } state_e;

   // ceil(log2(n)), floored at 1 so a single-word bank still has an address bit
   function automatic int unsigned addr_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/configs_bank.sv
// Shadow/active register banks: one write port, bulk shadow->active copy, two read ports.
module configs_bank #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_WORDS = 22,
   parameter int unsigned ADDR_W    = 5
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        we_i,
   input  logic [ADDR_W-1:0]           waddr_i,
   input  logic [DATA_W-1:0]           wdata_i,
   input  logic                        copy_i,
   input  logic [ADDR_W-1:0]           raddr_act_i,
   output logic [DATA_W-1:0]           rdata_act_o,
   input  logic [ADDR_W-1:0]           raddr_shd_i,
   output logic [DATA_W-1:0]           rdata_shd_o,
   output logic [NUM_WORDS*DATA_W-1:0] active_o
);

   logic [DATA_W-1:0] shadow_q [NUM_WORDS];
   logic [DATA_W-1:0] shadow_d [NUM_WORDS];
   logic [DATA_W-1:0] active_q [NUM_WORDS];
   logic [DATA_W-1:0] active_d [NUM_WORDS];

   always_comb begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         shadow_d[i] = (we_i && (waddr_i == ADDR_W'(i))) ? wdata_i : shadow_q[i];
         active_d[i] = copy_i ? shadow_q[i] : active_q[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   // Out-of-range addresses match no word and read as zero
   always_comb begin
      rdata_act_o = '0;
      rdata_shd_o = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (raddr_act_i == ADDR_W'(i)) rdata_act_o = active_q[i];
         if (raddr_shd_i == ADDR_W'(i)) rdata_shd_o = shadow_q[i];
      end
   end

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_active_out
      assign active_o[g*DATA_W +: DATA_W] = active_q[g];
   end

endmodule

// File: rtl/configs_loader.sv
// Burst loader for a double-buffered configuration register file with explicit
// or automatic commit of the shadow bank into the active bank.
module configs_loader
   import configs_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_WORDS   = 22,
   parameter int unsigned AUTO_COMMIT = 0,
   parameter int unsigned ADDR_W      = addr_width(NUM_WORDS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        io_start,
   input  logic [ADDR_W-1:0]           io_start_addr,
   input  logic [ADDR_W:0]             io_start_count,
   input  logic                        io_in_valid,
   output logic                        io_in_ready,
   input  logic [DATA_W-1:0]           io_d_in,
   input  logic                        io_commit,
   input  logic                        io_abort,
   input  logic [ADDR_W-1:0]           io_rd_addr,
   input  logic                        io_rd_sel,
   output logic [DATA_W-1:0]           io_rd_data,
   output logic                        io_busy,
   output logic                        io_load_done,
   output logic                        io_commit_done,
   output logic                        io_err,
   output logic [NUM_WORDS*DATA_W-1:0] io_configs_out
);

   localparam logic [ADDR_W+1:0] NumWordsX = (ADDR_W+2)'(NUM_WORDS);
   localparam logic [ADDR_W:0]   RemOne    = (ADDR_W+1)'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic                load_done_q, load_done_d;
   logic                commit_done_q, commit_done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic                bank_we;
   logic                bank_copy;
   logic [DATA_W-1:0]   rd_act;
   logic [DATA_W-1:0]   rd_shd;
   logic [ADDR_W+1:0]   start_end;
   logic                start_ok;

   assign start_end = {2'b00, io_start_addr} + {1'b0, io_start_count};
   assign start_ok  = (io_start_count != '0) && (start_end <= NumWordsX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rem_d         = rem_q;
      load_done_d   = 1'b0;
      commit_done_d = 1'b0;
      err_d         = 1'b0;
      case (state_q)
         StIdle: begin
            // io_start wins over io_commit, even when the start is rejected
            if (io_start) begin
               if (start_ok) begin
                  state_d = StLoad;
                  addr_d  = io_start_addr;
                  rem_d   = io_start_count;
               end else begin
                  err_d = 1'b1;
               end
            end else if (io_commit) begin
               state_d = StCommit;
            end
         end
         StLoad: begin
            err_d = io_start | io_commit;
            if (io_abort) begin
               state_d = StIdle;
            end else if (io_in_valid) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - RemOne;
               if (rem_q == RemOne) begin
                  load_done_d = 1'b1;
                  state_d     = (AUTO_COMMIT != 0) ? StCommit : StIdle;
               end
            end
         end
         StCommit: begin
            err_d         = io_start | io_commit;
            commit_done_d = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      io_in_ready = (state_q == StLoad);
      io_busy     = (state_q != StIdle);
      bank_we     = (state_q == StLoad) && io_in_valid && !io_abort;
      bank_copy   = (state_q == StCommit);
      rd_data_d   = io_rd_sel ? rd_shd : rd_act;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q        <= '0;
         rem_q         <= '0;
         load_done_q   <= 1'b0;
         commit_done_q <= 1'b0;
         err_q         <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         addr_q        <= addr_d;
         rem_q         <= rem_d;
         load_done_q   <= load_done_d;
         commit_done_q <= commit_done_d;
         err_q         <= err_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign io_load_done   = load_done_q;
   assign io_commit_done = commit_done_q;
   assign io_err         = err_q;
   assign io_rd_data     = rd_data_q;

   configs_bank #(
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_bank (
      .clk_i       (clk),
      .rst_i       (reset),
      .we_i        (bank_we),
      .waddr_i     (addr_q),
      .wdata_i     (io_d_in),
      .copy_i      (bank_copy),
      .raddr_act_i (io_rd_addr),
      .rdata_act_o (rd_act),
      .raddr_shd_i (io_rd_addr),
      .rdata_shd_o (rd_shd),
      .active_o    (io_configs_out)
   );

endmodule

// File: tb/tb_configs_loader.sv
// Scoreboard bench: two loaders (manual and auto commit) share one stimulus stream.
module tb_configs_loader;

   localparam int DW = 32;
   localparam int NW = 22;
   localparam int AW = 5;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      int               cyc;
      logic [1:0]       busy;
      logic [1:0]       ready;
      logic [NW*DW-1:0] cfg0;
      logic [NW*DW-1:0] cfg1;
   } st_t;

   logic clk;
   logic rst;
   logic start;
   logic [AW-1:0] st_addr;
   logic [AW:0] st_cnt;
   logic in_valid;
   logic [DW-1:0] d_in;
   logic commit;
   logic abort;
   logic [AW-1:0] rd_addr;
   logic rd_sel;
   logic rd_req;
   logic rd_req_q;

   logic ready0, busy0, ld0, cd0, err0;
   logic ready1, busy1, ld1, cd1, err1;
   logic [DW-1:0] rd_data0, rd_data1;
   logic [NW*DW-1:0] cfg0, cfg1;

   int edge_n = 0;
   int n_chk = 0;
   int n_fail = 0;

   ev_t evq[$];
   st_t stq[$];

   // Reference model: per-instance phase (0 idle, 1 loading, 2 committing)
   int          m_st[2];
   int          m_addr[2];
   int          m_rem[2];
   logic [31:0] m_sh[2][NW];
   logic [31:0] m_ac[2][NW];

   configs_loader #(.DATA_W(DW), .NUM_WORDS(NW), .AUTO_COMMIT(0)) dut0 (
      .clk(clk), .reset(rst), .io_start(start), .io_start_addr(st_addr),
      .io_start_count(st_cnt), .io_in_valid(in_valid), .io_in_ready(ready0), .io_d_in(d_in),
      .io_commit(commit), .io_abort(abort), .io_rd_addr(rd_addr), .io_rd_sel(rd_sel),
      .io_rd_data(rd_data0), .io_busy(busy0), .io_load_done(ld0), .io_commit_done(cd0),
      .io_err(err0), .io_configs_out(cfg0)
   );

   configs_loader #(.DATA_W(DW), .NUM_WORDS(NW), .AUTO_COMMIT(1)) dut1 (
      .clk(clk), .reset(rst), .io_start(start), .io_start_addr(st_addr),
      .io_start_count(st_cnt), .io_in_valid(in_valid), .io_in_ready(ready1), .io_d_in(d_in),
      .io_commit(commit), .io_abort(abort), .io_rd_addr(rd_addr), .io_rd_sel(rd_sel),
      .io_rd_data(rd_data1), .io_busy(busy1), .io_load_done(ld1), .io_commit_done(cd1),
      .io_err(err1), .io_configs_out(cfg1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      edge_n   <= edge_n + 1;
      rd_req_q <= rd_req;
   end

   function automatic string kname(input int k);
      case (k % 4)
         0:       return "load_done";
         1:       return "commit_done";
         2:       return "err";
         default: return "rd_data";
      endcase
   endfunction

   function automatic logic [NW*DW-1:0] pack_active(input int d);
      logic [NW*DW-1:0] v;
      for (int i = 0; i < NW; i++) v[i*DW +: DW] = m_ac[d][i];
      return v;
   endfunction

   task automatic push_ev(input int stamp, input int kind, input logic [31:0] data);
      ev_t e;
      e.cyc  = stamp;
      e.kind = kind;
      e.data = data;
      evq.push_back(e);
   endtask

   task automatic model_step(input int d, input bit auto_c, input int stamp);
      logic [31:0] rv;
      bit ld, cd, er;
      int sa, sc, ra;
      sa = int'(st_addr);
      sc = int'(st_cnt);
      ra = int'(rd_addr);
      ld = 0; cd = 0; er = 0;
      rv = '0;
      if (rst) begin
         m_st[d] = 0; m_addr[d] = 0; m_rem[d] = 0;
         for (int i = 0; i < NW; i++) begin
            m_sh[d][i] = '0;
            m_ac[d][i] = '0;
         end
      end else begin
         if (ra < NW) rv = rd_sel ? m_sh[d][ra] : m_ac[d][ra];
         if (m_st[d] == 0) begin
            if (start) begin
               if (sc >= 1 && sa + sc <= NW) begin
                  m_st[d] = 1; m_addr[d] = sa; m_rem[d] = sc;
               end else er = 1;
            end else if (commit) m_st[d] = 2;
         end else if (m_st[d] == 1) begin
            er = start | commit;
            if (abort) m_st[d] = 0;
            else if (in_valid) begin
               m_sh[d][m_addr[d]] = d_in;
               m_addr[d]++;
               m_rem[d]--;
               if (m_rem[d] == 0) begin
                  ld = 1;
                  m_st[d] = auto_c ? 2 : 0;
               end
            end
         end else begin
            er = start | commit;
            for (int i = 0; i < NW; i++) m_ac[d][i] = m_sh[d][i];
            cd = 1;
            m_st[d] = 0;
         end
      end
      if (ld) push_ev(stamp, d*4 + 0, '0);
      if (cd) push_ev(stamp, d*4 + 1, '0);
      if (er) push_ev(stamp, d*4 + 2, '0);
      if (rd_req) push_ev(stamp, d*4 + 3, rv);
   endtask

   task automatic tick();
      st_t s;
      model_step(0, 1'b0, edge_n);
      model_step(1, 1'b1, edge_n);
      s.cyc   = edge_n;
      s.busy  = {m_st[1] != 0, m_st[0] != 0};
      s.ready = {m_st[1] == 1, m_st[0] == 1};
      s.cfg0  = pack_active(0);
      s.cfg1  = pack_active(1);
      stq.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      rst = 0; start = 0; commit = 0; abort = 0; in_valid = 0; rd_req = 0;
   endtask

   task automatic idle(input int n);
      clear();
      repeat (n) tick();
   endtask

   task automatic do_start(input int a, input int c);
      clear();
      start = 1; st_addr = AW'(a); st_cnt = (AW+1)'(c);
      tick();
      start = 0;
   endtask

   task automatic word(input logic [31:0] w);
      clear();
      in_valid = 1; d_in = w;
      tick();
      in_valid = 0;
   endtask

   task automatic rd(input int a, input bit s);
      clear();
      rd_req = 1; rd_addr = AW'(a); rd_sel = s;
      tick();
      rd_req = 0;
   endtask

   task automatic see(input int c, input int kind, input logic [31:0] got);
      n_chk++;
      if (evq.size() != 0 && evq[0].cyc == c && evq[0].kind == kind) begin
         if (kind % 4 == 3 && got !== evq[0].data) begin
            n_fail++;
            $display("FAIL rd_data dut%0d cyc %0d: got %h expected %h", kind / 4, c, got,
                     evq[0].data);
         end
         void'(evq.pop_front());
      end else begin
         n_fail++;
         $display("FAIL unexpected %s dut%0d cyc %0d: got pulse/value %h, expected none",
                  kname(kind), kind / 4, c, got);
      end
   endtask

   always @(negedge clk) begin
      int c;
      st_t s;
      c = edge_n - 1;
      if (stq.size() != 0 && stq[0].cyc == c) begin
         s = stq.pop_front();
         n_chk += 4;
         if ({busy1, busy0} !== s.busy) begin
            n_fail++;
            $display("FAIL busy cyc %0d: got %b expected %b", c, {busy1, busy0}, s.busy);
         end
         if ({ready1, ready0} !== s.ready) begin
            n_fail++;
            $display("FAIL in_ready cyc %0d: got %b expected %b", c, {ready1, ready0}, s.ready);
         end
         if (cfg0 !== s.cfg0) begin
            n_fail++;
            $display("FAIL configs_out dut0 cyc %0d: got %h expected %h", c, cfg0, s.cfg0);
         end
         if (cfg1 !== s.cfg1) begin
            n_fail++;
            $display("FAIL configs_out dut1 cyc %0d: got %h expected %h", c, cfg1, s.cfg1);
         end
      end
      while (evq.size() != 0 && evq[0].cyc < c) begin
         n_chk++;
         n_fail++;
         $display("FAIL missing %s dut%0d cyc %0d: got none expected pulse/value %h",
                  kname(evq[0].kind), evq[0].kind / 4, evq[0].cyc, evq[0].data);
         void'(evq.pop_front());
      end
      if (ld0 === 1'b1)  see(c, 0, '0);
      if (cd0 === 1'b1)  see(c, 1, '0);
      if (err0 === 1'b1) see(c, 2, '0);
      if (rd_req_q)      see(c, 3, rd_data0);
      if (ld1 === 1'b1)  see(c, 4, '0);
      if (cd1 === 1'b1)  see(c, 5, '0);
      if (err1 === 1'b1) see(c, 6, '0);
      if (rd_req_q)      see(c, 7, rd_data1);
   end

   initial begin
      clear();
      rst = 1; st_addr = '0; st_cnt = '0; d_in = '0; rd_addr = '0; rd_sel = 0;
      @(posedge clk);
      #1;
      rst = 1;
      tick();
      tick();

      // Burst of four words with valid gaps, then explicit commit and readback
      do_start(3, 4);
      for (int i = 0; i < 4; i++) begin
         word(32'hA0 + 32'(i));
         idle(1);
      end
      idle(2);
      clear(); commit = 1; tick();
      idle(3);
      for (int i = 2; i < 8; i++) rd(i, 1'b1);
      rd(5, 1'b0);
      rd(4, 1'b0);
      rd(25, 1'b1);

      // Range boundary: rejected then accepted at the top word
      do_start(20, 3);
      idle(1);
      do_start(21, 1);
      word(32'h5555_0021);
      idle(3);
      do_start(0, 0);
      idle(1);

      // Two-word load at address 0 (the auto-commit instance commits on its own)
      do_start(0, 2);
      word(32'h11);
      word(32'h22);
      idle(4);
      rd(0, 1'b0);
      rd(1, 1'b0);

      // Abort after two of five words, start during load, commit+start in idle
      do_start(0, 5);
      word(32'hB0);
      clear(); start = 1; st_addr = '0; st_cnt = 6'd1; tick();
      word(32'hB1);
      clear(); abort = 1; in_valid = 1; d_in = 32'hDEAD; tick();
      idle(1);
      rd(2, 1'b1);
      rd(1, 1'b1);
      clear(); start = 1; commit = 1; st_addr = 5'd30; st_cnt = 6'd2; tick();
      idle(2);

      // Same-cycle write and shadow readback returns the old word
      do_start(6, 1);
      clear(); in_valid = 1; d_in = 32'hC6C6; rd_req = 1; rd_addr = 5'd6; rd_sel = 1; tick();
      rd(6, 1'b1);

      // Reset mid-burst
      do_start(0, 4);
      word(32'hE0);
      clear(); rst = 1; tick();
      rd(0, 1'b1);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         clear();
         rst      = ($urandom_range(0, 299) == 0);
         start    = ($urandom_range(0, 11) == 0);
         st_addr  = AW'($urandom_range(0, 31));
         st_cnt   = (AW+1)'($urandom_range(0, 24));
         commit   = ($urandom_range(0, 9) == 0);
         abort    = ($urandom_range(0, 29) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         d_in     = $urandom;
         rd_req   = $urandom_range(0, 1) == 1;
         rd_addr  = AW'($urandom_range(0, 31));
         rd_sel   = $urandom_range(0, 1) == 1;
         tick();
      end
      idle(4);
      @(negedge clk);
      #1;
      while (evq.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL missing %s dut%0d cyc %0d: got none expected pulse/value %h",
                  kname(evq[0].kind), evq[0].kind / 4, evq[0].cyc, evq[0].data);
         void'(evq.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
